// File: rtl/edge_mcu_param.sv
// Main control unit for the edge-detection pipeline: sequences window reads, the
// Sobel calculate period, the result write and the buffer clear, and counts windows per frame.
module edge_mcu_param #(
  parameter int unsigned READ_ROWS    = 3,
  parameter int unsigned CALC_CYCLES  = 2,
  parameter int unsigned WRITE_HS     = 1,
  parameter int unsigned PIX_W        = 16,
  parameter int unsigned FRAME_PIXELS = 1024,
  localparam int unsigned ROW_W       = (READ_ROWS > 1) ? $clog2(READ_ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_enable_r,
  input  logic             transfer_data_complete_r,
  input  logic             transfer_data_complete_w,
  input  logic             abort,
  output logic             enable_calc,
  output logic             buffer_clear,
  output logic             write_req,
  output logic             busy,
  output logic [ROW_W-1:0] row_idx,
  output logic [PIX_W-1:0] pixel_count,
  output logic             frame_done
);

  localparam int unsigned CALC_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(READ_ROWS - 1);
  localparam logic [CALC_W-1:0] CALC_LAST = CALC_W'(CALC_CYCLES - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(FRAME_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CALC  = 3'd2,
    WRITE = 3'd3,
    CLEAR = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [ROW_W-1:0]   row_cnt, row_n;
  logic [CALC_W-1:0]  calc_cnt, calc_n;
  logic [PIX_W-1:0]   pix_n;
  logic               enable_calc_n, buffer_clear_n, write_req_n, busy_n, frame_done_n;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state, next-counter and next-output decode
  always_comb begin
    state_n  = state;
    row_n    = row_cnt;
    calc_n   = calc_cnt;
    pix_n    = pixel_count;

    case (state)
      IDLE: begin
        if (!abort && shift_enable_r) state_n = READ;
      end
      READ: begin
        if (transfer_data_complete_r) begin
          if (row_cnt == ROW_LAST) begin
            row_n   = '0;
            calc_n  = '0;
            state_n = CALC;
          end else begin
            row_n = row_cnt + ROW_W'(1);
          end
        end
      end
      CALC: begin
        if (calc_cnt == CALC_LAST) begin
          calc_n  = '0;
          state_n = WRITE;
        end else begin
          calc_n = calc_cnt + CALC_W'(1);
        end
      end
      WRITE: begin
        if ((WRITE_HS == 0) || transfer_data_complete_w) state_n = CLEAR;
      end
      CLEAR: begin
        state_n = IDLE;
        pix_n   = (pixel_count == PIX_LAST) ? '0 : pixel_count + PIX_W'(1);
      end
      default: begin
        state_n = IDLE;
        row_n   = '0;
        calc_n  = '0;
      end
    endcase

    // Abort abandons the window without touching the frame count
    if (abort && (state != IDLE)) begin
      state_n = IDLE;
      row_n   = '0;
      calc_n  = '0;
      pix_n   = pixel_count;
    end

    enable_calc_n  = (state_n == CALC) && (calc_n == '0);
    write_req_n    = (state_n == WRITE);
    buffer_clear_n = (state_n == CLEAR);
    busy_n         = (state_n != IDLE);
    frame_done_n   = (state_n == CLEAR) && (pix_n == PIX_LAST);
  end

  // Counters and output flops load the decode of the next state, keeping outputs Moore
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt      <= '0;
      calc_cnt     <= '0;
      pixel_count  <= '0;
      enable_calc  <= 1'b0;
      write_req    <= 1'b0;
      buffer_clear <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      row_cnt      <= row_n;
      calc_cnt     <= calc_n;
      pixel_count  <= pix_n;
      enable_calc  <= enable_calc_n;
      write_req    <= write_req_n;
      buffer_clear <= buffer_clear_n;
      busy         <= busy_n;
      frame_done   <= frame_done_n;
    end
  end

  assign row_idx = row_cnt;

endmodule

// File: tb/tb_edge_mcu_param.sv
// Scoreboard bench for edge_mcu_param: three parameter sets, directed windows with
// hand-derived event timing queued by stimulus and checked by an output monitor.
module tb_edge_mcu_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] se = '0, tr = '0, tw = '0, ab = '0;
  logic [2:0] en, wr, cl, bz, fd;
  logic [1:0] ri_a, ri_b;
  logic [2:0] ri_c;
  logic [15:0] pc_a, pc_b, pc_c;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  // Per-instance configuration: A = defaults/no handshake/4-pixel frame, B = handshake, C = 5 rows/1 calc
  int rows_of [3] = '{3, 3, 5};
  int calc_of [3] = '{2, 2, 1};
  int hs_of   [3] = '{0, 1, 0};
  int fp_of   [3] = '{4, 1024, 1024};
  int pc_model[3] = '{0, 0, 0};

  typedef struct {
    int d;
    int cyc;
    int kind;
    int pix;
    int fd;
  } ev_t;
  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  edge_mcu_param #(.READ_ROWS(3), .CALC_CYCLES(2), .WRITE_HS(0), .PIX_W(16), .FRAME_PIXELS(4)) dut_a (
    .clk(clk), .rst(rst), .shift_enable_r(se[0]), .transfer_data_complete_r(tr[0]),
    .transfer_data_complete_w(tw[0]), .abort(ab[0]), .enable_calc(en[0]), .buffer_clear(cl[0]),
    .write_req(wr[0]), .busy(bz[0]), .row_idx(ri_a), .pixel_count(pc_a), .frame_done(fd[0]));

  edge_mcu_param #(.READ_ROWS(3), .CALC_CYCLES(2), .WRITE_HS(1), .PIX_W(16), .FRAME_PIXELS(1024)) dut_b (
    .clk(clk), .rst(rst), .shift_enable_r(se[1]), .transfer_data_complete_r(tr[1]),
    .transfer_data_complete_w(tw[1]), .abort(ab[1]), .enable_calc(en[1]), .buffer_clear(cl[1]),
    .write_req(wr[1]), .busy(bz[1]), .row_idx(ri_b), .pixel_count(pc_b), .frame_done(fd[1]));

  edge_mcu_param #(.READ_ROWS(5), .CALC_CYCLES(1), .WRITE_HS(0), .PIX_W(16), .FRAME_PIXELS(1024)) dut_c (
    .clk(clk), .rst(rst), .shift_enable_r(se[2]), .transfer_data_complete_r(tr[2]),
    .transfer_data_complete_w(tw[2]), .abort(ab[2]), .enable_calc(en[2]), .buffer_clear(cl[2]),
    .write_req(wr[2]), .busy(bz[2]), .row_idx(ri_c), .pixel_count(pc_c), .frame_done(fd[2]));

  function automatic int get_ri(input int d);
    case (d)
      0:       return int'(ri_a);
      1:       return int'(ri_b);
      default: return int'(ri_c);
    endcase
  endfunction

  function automatic int get_pc(input int d);
    case (d)
      0:       return int'(pc_a);
      1:       return int'(pc_b);
      default: return int'(pc_c);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
    chk("stimulus_alignment", cyc, target);
  endtask

  // Queue an expected strobe unless an abort at cycle ac precedes it (ac = 0: no abort)
  task automatic push_ev(input int d, input int c, input int kind, input int pix, input int f, input int ac);
    ev_t e;
    if (ac == 0 || c <= ac) begin
      e.d = d; e.cyc = c; e.kind = kind; e.pix = pix; e.fd = f;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every cycle an instance shows a strobe, it must match the head of the queue
  ev_t m_e;
  int  m_kind;
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (en[d] | wr[d] | cl[d] | fd[d]) begin
          m_kind = int'({cl[d], wr[d], en[d]});
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_strobe: dut%0d cycle %0d kind %0d fd %0d, none expected",
                     d, cyc, m_kind, int'(fd[d]));
          end else begin
            m_e = exp_q.pop_front();
            if (m_e.d != d || m_e.cyc != cyc || m_e.kind != m_kind ||
                m_e.pix != get_pc(d) || m_e.fd != int'(fd[d])) begin
              miscompares++;
              $display("FAIL strobe: got dut%0d cyc %0d kind %0d pix %0d fd %0d; expected dut%0d cyc %0d kind %0d pix %0d fd %0d",
                       d, cyc, m_kind, get_pc(d), int'(fd[d]),
                       m_e.d, m_e.cyc, m_e.kind, m_e.pix, m_e.fd);
            end
          end
        end
      end
    end
  end

  task automatic chk_idle(input int d, input string nm);
    chk({nm, "_busy"}, int'(bz[d]), 0);
    chk({nm, "_row_idx"}, get_ri(d), 0);
    chk({nm, "_pixel_count"}, get_pc(d), pc_model[d]);
  endtask

  // One window: 2 idle cycles before each row pulse; abort_off>0 aborts at (last pulse + abort_off)
  task automatic window(input int d, input int wdelay, input int abort_off, input bit stray);
    int t, ws, wl, cl_c, end_c, ac, pix0, fd0;
    t = 0;
    se[d] = 1'b1; tick(); se[d] = 1'b0;
    for (int r = 0; r < rows_of[d]; r++) begin
      tick(); tick();
      tr[d] = 1'b1; t = cyc; tick(); tr[d] = 1'b0;
      chk($sformatf("row_idx_dut%0d_row%0d", d, r), get_ri(d), (r == rows_of[d] - 1) ? 0 : r + 1);
    end
    ws   = t + calc_of[d] + 1;
    wl   = (hs_of[d] != 0) ? wdelay + 1 : 1;
    cl_c = ws + wl;
    ac   = (abort_off != 0) ? t + abort_off : 0;
    pix0 = pc_model[d];
    fd0  = (pix0 == fp_of[d] - 1) ? 1 : 0;
    push_ev(d, t + 1, 1, pix0, 0, ac);
    for (int k = 0; k < wl; k++) push_ev(d, ws + k, 2, pix0, 0, ac);
    push_ev(d, cl_c, 4, pix0, fd0, ac);
    if (stray) begin
      tr[d] = 1'b1; tw[d] = 1'b1; tick(); tr[d] = 1'b0; tw[d] = 1'b0;
    end
    if (ac != 0) begin
      wait_until(ac);
      ab[d] = 1'b1; tick(); ab[d] = 1'b0;
      end_c = ac + 1;
    end else begin
      if (hs_of[d] != 0) begin
        wait_until(ws + wdelay);
        tw[d] = 1'b1; tick(); tw[d] = 1'b0;
      end
      end_c = cl_c + 1;
      pc_model[d] = (pix0 == fp_of[d] - 1) ? 0 : pix0 + 1;
    end
    wait_until(end_c);
    chk_idle(d, $sformatf("end_dut%0d", d));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    pc_model = '{0, 0, 0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    do_reset();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_strobes_dut%0d", d), int'({en[d], wr[d], cl[d], bz[d], fd[d]}), 0);
      chk_idle(d, $sformatf("reset_dut%0d", d));
    end

    // Stray row/write pulses in IDLE do nothing
    tr[0] = 1'b1; tw[0] = 1'b1; tick(); tr[0] = 1'b0; tw[0] = 1'b0;
    tick();
    chk_idle(0, "stray_idle");

    // A: nominal, abort in CALC, then four more windows across the frame wrap
    window(0, 0, 0, 1'b0);
    window(0, 0, 1, 1'b0);
    window(0, 0, 0, 1'b1);
    window(0, 0, 0, 1'b0);
    window(0, 0, 0, 1'b0);
    window(0, 0, 0, 1'b0);

    // B: delayed handshake, first-cycle handshake, abort in WRITE, fresh window
    window(1, 5, 0, 1'b0);
    window(1, 0, 0, 1'b0);
    window(1, 5, 4, 1'b0);
    window(1, 2, 0, 1'b0);

    // C: abort in IDLE blocks a simultaneous start, then two windows
    se[2] = 1'b1; ab[2] = 1'b1; tick(); se[2] = 1'b0; ab[2] = 1'b0;
    chk("idle_abort_busy", int'(bz[2]), 0);
    tick();
    chk("idle_abort_no_queue", int'(bz[2]), 0);
    window(2, 0, 0, 1'b1);
    window(2, 0, 0, 1'b0);

    // Reset in the middle of READ clears everything, including pixel_count
    se[0] = 1'b1; tick(); se[0] = 1'b0;
    for (int r = 0; r < 2; r++) begin
      tick(); tr[0] = 1'b1; tick(); tr[0] = 1'b0;
    end
    chk("pre_reset_row_idx", get_ri(0), 2);
    chk("pre_reset_pixel_count", get_pc(0), pc_model[0]);
    do_reset();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midreset_strobes_dut%0d", d), int'({en[d], wr[d], cl[d], bz[d], fd[d]}), 0);
      chk_idle(d, $sformatf("midreset_dut%0d", d));
    end

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
